mult_seq_unit: RTL and testbench

//  Iterative 32x32 multiplier for MULT/MULTU, downstream consumer of the 32-bit

---
 rtl/mult_seq_unit.sv | 123 ++++++++++++
 tb/tb_mult_seq_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_unit.sv
// Iterative 32x32 MULT/MULTU: one shift-and-add step per clock, product lands in hi/lo.
// Latency: fixed 33 clocks from the accepting edge to the done pulse, no early exit.
// Backpressure: start is taken only in IDLE; requests while busy are dropped without effect.
module mult_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mcand_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               neg, neg_nxt;
    logic               busy_nxt, done_nxt;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;

    // Operand magnitudes; a most-negative signed operand maps to 2^(WIDTH-1) unsigned.
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_fixed;

    always_comb begin
        a_mag = (is_signed && op_a[WIDTH-1]) ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
        b_mag = (is_signed && op_b[WIDTH-1]) ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
    end

    // The 33-bit add keeps its carry, which becomes the new top bit of the accumulator.
    always_comb begin
        if (acc[0]) begin
            step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        prod_fixed = neg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
    end

    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        neg_nxt   = neg;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        hi_nxt    = hi;
        lo_nxt    = lo;

        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt = CALC;
                    mcand_nxt = a_mag;
                    acc_nxt   = {{WIDTH{1'b0}}, b_mag};
                    cnt_nxt   = '0;
                    neg_nxt   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    busy_nxt  = 1'b1;
                end
            end
            CALC: begin
                acc_nxt = {step_sum, acc[WIDTH-1:1]};
                cnt_nxt = cnt + {{(CW-1){1'b0}}, 1'b1};
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                hi_nxt    = prod_fixed[2*WIDTH-1:WIDTH];
                lo_nxt    = prod_fixed[WIDTH-1:0];
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            mcand <= mcand_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            neg   <= neg_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_mult_seq_unit.sv
// Bench for mult_seq_unit: directed vectors with literal expectations plus a
// cycle-level reference model (64-bit product, 33-clock countdown) compared every cycle.
module tb_mult_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int errs    = 0;
    bit cmp_en  = 1'b0;

    mult_seq_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Reference model: accept when idle, result appears 33 clocks later.
    logic        m_busy, m_done;
    logic [63:0] m_prod, m_res;
    int          m_left;

    function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (sg) return 64'(sa * sb);
        return ua * ub;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 64'd0;
            m_prod = 64'd0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_prod;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = 33;
                m_prod = ref_prod(is_signed, op_a, op_b);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("hilo", {hi, lo}, m_res);
            chk("busy_and_done", {63'd0, busy & done}, 64'd0);
        end
    end

    // Issue one operation and wait for done; returns clocks from accept edge to done.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; is_signed = sg; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directed(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
        int lat;
        issue(sg, a, b, lat);
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_result"}, {hi, lo}, exp);
        chk({name, "_model"}, m_res, exp);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        directed("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        directed("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        directed("mult_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        directed("multu_minmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        directed("mult_min_x1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        directed("mult_zero", 1'b1, 32'd0, 32'hDEAD_BEEF, 64'd0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; op_a = 32'd7; op_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                start = 1'b1; op_a = 32'd2; op_b = 32'd2;
            end else if (lat == 6) begin
                start = 1'b0;
            end
        end
        chk("ignore_latency", 64'(lat), 64'd33);
        chk("ignore_result", {hi, lo}, 64'd42);
        start = 1'b1; is_signed = 1'b1; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_result", {hi, lo}, 64'd9);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("restart", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);

        // Random pairs with junk start pulses while busy; the per-cycle compare does the checking.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b1; is_signed = $urandom_range(0, 1); op_a = $urandom; op_b = $urandom;
            if (i % 8 == 0) op_a = 32'h8000_0000;
            if (i % 11 == 0) op_b = 32'hFFFF_FFFF;
            @(negedge clk);
            start = 1'b0;
            lat = 0;
            while (!done && lat < 40) begin
                if (lat < 30) begin
                    start = $urandom_range(0, 3) == 0;
                    op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
            start = 1'b0;
            chk("rand_latency", 64'(lat), 64'd33);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
